// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: one-deep pipelined bitwise logic unit.
// It has run-time operation select and an accumulate mode that feeds the previous result back as B.
// The result register carries zero/ones/parity flags and a wrapping accepted-operation counter.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpNor  = 3'd2,
    OpNand = 3'd3,
    OpXor  = 3'd4,
    OpXnor = 3'd5,
    OpInv  = 3'd6,
    OpPass = 3'd7
  } op_e;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_ones;
  logic             r_parity;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_drain;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_result;

  // The single output register frees up whenever it is empty or being drained this cycle.
  assign w_in_ready = !r_out_valid || out_ready;
  // Reset wins over any handshake at the same edge.
  assign w_accept   = in_valid && w_in_ready && !reset;
  assign w_drain    = r_out_valid && out_ready;
  assign w_b_eff    = acc_en ? r_acc : b;

  // Bitwise operation select; INV and PASS look only at a.
  always_comb begin
    w_result = '0;
    unique case (op_e'(op))
      OpAnd:   w_result = a & w_b_eff;
      OpOr:    w_result = a | w_b_eff;
      OpNor:   w_result = ~(a | w_b_eff);
      OpNand:  w_result = ~(a & w_b_eff);
      OpXor:   w_result = a ^ w_b_eff;
      OpXnor:  w_result = ~(a ^ w_b_eff);
      OpInv:   w_result = ~a;
      OpPass:  w_result = a;
      default: w_result = '0;
    endcase
  end

  // Pipeline register: load on accept, clear valid on a bare drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_ones      <= 1'b0;
      r_parity    <= 1'b0;
      r_acc       <= '0;
      r_op_count  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
      r_zero      <= ~|w_result;
      r_ones      <= &w_result;
      r_parity    <= ^w_result;
      r_acc       <= w_result;
      r_op_count  <= r_op_count + CNT_W'(1);
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign ones      = r_ones;
  assign parity    = r_parity;
  assign op_count  = r_op_count;

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised successor to the two-input gate set. Adds WIDTH-bit bitwise operands and run-time operation select.
- Adds a registered output stage with a valid/ready handshake, an accumulate mode that chains results, result flags and a wrapping operation counter.
- Sits between a producer (operand source) and a consumer (display/register logic) as a one-deep pipelined logic unit.

Parameters:
- WIDTH, 8, operand/result width in bits (1..32).
- CNT_W, 8, width of the accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- op  input  3  0 AND, 1 OR, 2 NOR, 3 NAND, 4 XOR, 5 XNOR, 6 INV(a), 7 PASS(a).
- acc_en  input  1  1 = use the internal accumulator in place of b.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for ops 6, 7 and when acc_en=1).
- out_valid  output  1  result registered and pending.
- out_ready  input  1  consumer takes the result this cycle.
- y  output  WIDTH  registered result.
- zero  output  1  y == 0.
- ones  output  1  y == all ones.
- parity  output  1  XOR-reduction of y.
- op_count  output  CNT_W  number of accepted operations, modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. All state changes on the rising edge of clk.
- Reset values: out_valid=0, y=0, zero=0, ones=0, parity=0, op_count=0, internal acc=0.
  - zero is held 0 during reset; it is not derived from y while reset is asserted.
  - in_ready=1 in the first cycle after reset deasserts.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational, one-entry pipeline register).
  - Accept occurs when in_valid & in_ready.
  - Drain occurs when out_valid & out_ready.
- Latency: a result accepted at edge N is visible on y/out_valid after edge N (1-cycle latency). Full throughput of 1 op/cycle when out_ready stays high.
- On accept:
  - operand B' = acc_en ? acc : b.
  - y <= f(op, a, B'), computed bitwise over all WIDTH bits.
  - flags are computed from the new y and registered together with it.
  - out_valid <= 1.
  - acc <= new y.
  - op_count <= op_count + 1, wrapping from 2^CNT_W-1 to 0.
- Drain without accept: out_valid <= 0. y, flags and acc hold their last values.
- Simultaneous drain and accept: the new result replaces the old one and out_valid stays 1, with no bubble.
- Backpressure (out_valid=1, out_ready=0):
  - in_ready=0.
  - y, flags, acc and op_count are frozen.
  - in_valid/op/a/b are ignored; the producer must hold them.
- acc reflects only accepted results. It is unaffected by stalls and by drains.
- op_count counts accepts, not drains.
- Reset mid-operation (reset=1 while out_valid=1 or while stalled): the pending result is discarded and every register returns to its reset value at that edge. in_ready during reset is a don't-care; no accept occurs while reset=1.
- Operations 6 and 7 never use b or acc, even when acc_en=1. They still update acc.
- No state machine beyond the out_valid bit. No arithmetic other than the counter increment.

Test Plan:
- Reset, then with WIDTH=8, out_ready=1, a=8'hF0, b=8'h3C, issue op 0..7 on consecutive cycles -> y = 30, FC, 03, CF, CC, 33, 0F, F0, one per cycle, out_valid continuous, op_count=8.
  - Flags for the XOR result (CC): zero=0, ones=0, parity=0.
- Accumulate chain: op=4 (XOR), acc_en=0, a=8'hAA, b=8'h00 -> y=AA. Then acc_en=1, a=8'hFF -> y=55. Then acc_en=1, a=8'h55 -> y=00, zero=1, parity=0.
- Backpressure: accept y=8'h0F, then hold out_ready=0 for 3 cycles with in_valid=1, op=1 -> in_ready=0, y stays 0F, op_count unchanged. Raise out_ready -> the new op is accepted that cycle and y updates at the next edge, with no bubble.
- Counter wrap: CNT_W=3, perform 9 accepts -> op_count reads 1. ones=1 when op=7, a=8'hFF.
- Reset mid-stall: out_valid=1, out_ready=0, y=8'h5A, then assert reset for 1 cycle -> next cycle out_valid=0, y=0, op_count=0, in_ready=1. A following acc_en=1, op=1, a=8'h00 gives y=00, proving acc was cleared.
